// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the memory-game input stage: state codes and default
// sizing, also used by the controller's db_estado decoder.
package detector_jogada_pkg;

  localparam int WIDTH_PADRAO    = 4;
  localparam int DEBOUNCE_PADRAO = 2;
  localparam int TIMEOUT_PADRAO  = 3000;  // 3 s at a 1 kHz game clock

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    ESPERA = 3'd1,
    FILTRO = 3'd2,
    SOLTA  = 3'd3
  } estado_t;

endpackage

// File: rtl/detector_jogada_sincronizador.sv
// Parameterized-width two-flop synchronizer for asynchronous level inputs
// (player switches, the start button).
module detector_jogada_sincronizador #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sinc_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge, forming a true two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
    end
  end

  assign q_o = sinc_q;

endmodule

// File: rtl/detector_jogada.sv
// Memory-game input stage: synchronizes and debounces the switches, qualifies
// each press as one play, flags multi-key presses and raises a play timeout.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int WIDTH           = WIDTH_PADRAO,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_PADRAO
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             habilita,
  input  logic [WIDTH-1:0] chaves,
  output logic [WIDTH-1:0] jogada,
  output logic             jogada_feita,
  output logic             jogada_invalida,
  output logic             timeout,
  output logic [2:0]       db_estado
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ULTIMO = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ULTIMO = DW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s;

  estado_t          estado_q,   estado_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [DW-1:0]    deb_q,      deb_d;
  logic [WIDTH-1:0] amostra_q,  amostra_d;
  logic [WIDTH-1:0] jogada_q,   jogada_d;
  logic             feita_q,    feita_d;
  logic             invalida_q, invalida_d;
  logic             timeout_q,  timeout_d;

  logic             qualifica;
  logic [WIDTH-1:0] candidato;

  detector_jogada_sincronizador #(.WIDTH(WIDTH)) u_sinc (
    .clk   (clock),
    .rst_n (reset),
    .d_i   (chaves),
    .q_o   (s)
  );

  function automatic logic eh_one_hot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    deb_d      = deb_q;
    amostra_d  = amostra_q;
    jogada_d   = jogada_q;
    feita_d    = 1'b0;
    invalida_d = 1'b0;
    timeout_d  = 1'b0;
    qualifica  = 1'b0;
    candidato  = amostra_q;

    if (!habilita) begin
      estado_d = OCIOSO;
      deb_d    = '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          estado_d = ESPERA;
          cnt_d    = '0;
          deb_d    = '0;
        end
        ESPERA: begin
          if (s != '0) begin
            amostra_d = s;
            if (DEBOUNCE_CYCLES == 1) begin
              qualifica = 1'b1;
              candidato = s;
            end else begin
              estado_d = FILTRO;
              deb_d    = DW'(1);
            end
          end else if (cnt_q == CNT_ULTIMO) begin
            timeout_d = 1'b1;
            estado_d  = OCIOSO;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        FILTRO: begin
          if (s == amostra_q) begin
            if (deb_q == DEB_ULTIMO) qualifica = 1'b1;
            else                     deb_d     = deb_q + 1'b1;
          end else begin
            // A bounce resumes the wait; the play timer keeps its progress.
            estado_d = ESPERA;
            deb_d    = '0;
          end
        end
        SOLTA: begin
          if (s != '0) begin
            deb_d = '0;
          end else if (deb_q == DEB_ULTIMO) begin
            estado_d = ESPERA;
            cnt_d    = '0;
            deb_d    = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        default: estado_d = OCIOSO;
      endcase

      if (qualifica) begin
        jogada_d   = candidato;
        feita_d    = eh_one_hot(candidato);
        invalida_d = !eh_one_hot(candidato);
        estado_d   = SOLTA;
        deb_d      = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      cnt_q      <= '0;
      deb_q      <= '0;
      amostra_q  <= '0;
      jogada_q   <= '0;
      feita_q    <= 1'b0;
      invalida_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      amostra_q  <= amostra_d;
      jogada_q   <= jogada_d;
      feita_q    <= feita_d;
      invalida_q <= invalida_d;
      timeout_q  <= timeout_d;
    end
  end

  assign jogada          = jogada_q;
  assign jogada_feita    = feita_q;
  assign jogada_invalida = invalida_q;
  assign timeout         = timeout_q;
  assign db_estado       = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: directed presses, glitches, timeouts
// and aborts, with every pulse checked for kind, held play and cycle.
module tb_detector_jogada;

  localparam int T = 3000;
  localparam int K_FEITA    = 0;
  localparam int K_INVALIDA = 1;
  localparam int K_TIMEOUT  = 2;

  typedef struct {
    int         tipo;
    logic [3:0] jogada;
    int         ciclo;
  } esperado_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [3:0] chaves;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic       timeout;
  logic [2:0] db_estado;

  int n_vec = 0;
  int n_err = 0;
  int ciclo = 0;
  esperado_t fila[$];

  detector_jogada dut (
    .clock           (clock),
    .reset           (reset),
    .habilita        (habilita),
    .chaves          (chaves),
    .jogada          (jogada),
    .jogada_feita    (jogada_feita),
    .jogada_invalida (jogada_invalida),
    .timeout         (timeout),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic check(input string nome, input int real_v, input int esperado);
    n_vec++;
    if (real_v !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nome, real_v, real_v, esperado, esperado, ciclo);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ate(input int c);
    while (ciclo < c) @(negedge clock);
  endtask

  task automatic espera(input int tipo, input logic [3:0] j, input int c);
    esperado_t e;
    e.tipo = tipo; e.jogada = j; e.ciclo = c;
    fila.push_back(e);
  endtask

  // Monitor: every pulse the DUT shows is matched against the scoreboard.
  always @(negedge clock) begin
    int n;
    int tipo_real;
    esperado_t e;
    n = int'(jogada_feita) + int'(jogada_invalida) + int'(timeout);
    if (n > 1) begin
      check("um_pulso_por_ciclo", n, 1);
    end else if (n == 1) begin
      if (fila.size() == 0) begin
        check("pulso_inesperado", n, 0);
      end else begin
        e = fila.pop_front();
        tipo_real = jogada_feita ? K_FEITA : (jogada_invalida ? K_INVALIDA : K_TIMEOUT);
        check("tipo_pulso", tipo_real, e.tipo);
        check("jogada_no_pulso", int'(jogada), int'(e.jogada));
        check("ciclo_pulso", ciclo, e.ciclo);
      end
    end
  end

  initial begin
    int p, m, e1, e2, e3;
    reset = 1'b0; habilita = 1'b0; chaves = 4'b0000;

    // Reset state
    tick(10);
    check("reset_jogada", int'(jogada), 0);
    check("reset_feita", int'(jogada_feita), 0);
    check("reset_invalida", int'(jogada_invalida), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_estado", int'(db_estado), 0);
    reset = 1'b1; chaves = 4'b0001;
    tick(6);
    check("ocioso_sem_habilita", int'(db_estado), 0);
    chaves = 4'b0000;
    tick(4);
    habilita = 1'b1;
    tick(1);
    check("entra_espera", int'(db_estado), 1);
    tick(2);

    // Valid single press, then release
    p = ciclo;
    chaves = 4'b0010;
    espera(K_FEITA, 4'b0010, p + 4);
    tick(5);
    check("jogada_0010", int'(jogada), 4'h2);
    chaves = 4'b0000;
    m = ciclo;
    tick(3);
    check("solta_aguarda", int'(db_estado), 3);
    tick(1);
    check("volta_espera", int'(db_estado), 1);
    e1 = m + 4;

    // Single-cycle glitch: bounce through FILTRO, timer frozen two edges
    tick(2);
    chaves = 4'b0100;
    tick(1);
    chaves = 4'b0000;
    tick(2);
    check("glitch_filtro", int'(db_estado), 2);
    tick(1);
    check("glitch_volta", int'(db_estado), 1);
    espera(K_TIMEOUT, 4'b0010, e1 + T + 2);
    ate(e1 + T + 2);
    check("timeout1_ocioso", int'(db_estado), 0);

    // Clean timeout with habilita held: re-entry on the next edge
    e2 = e1 + T + 3;
    espera(K_TIMEOUT, 4'b0010, e2 + T);
    ate(e2 + T - 1);
    check("sem_timeout_2999", int'(db_estado), 1);
    tick(1);
    check("timeout2_ocioso", int'(db_estado), 0);
    e3 = e2 + T + 1;

    // Late press just before timeout expiry
    ate(e3 + 2990);
    p = ciclo;
    chaves = 4'b0001;
    espera(K_FEITA, 4'b0001, p + 4);
    tick(5);
    check("jogada_tardia", int'(jogada), 4'h1);
    chaves = 4'b0000;
    tick(6);

    // Multi-key press
    p = ciclo;
    chaves = 4'b0011;
    espera(K_INVALIDA, 4'b0011, p + 4);
    tick(5);
    chaves = 4'b0000;
    tick(6);
    check("jogada_0011", int'(jogada), 4'h3);

    // habilita dropped while filtering
    p = ciclo;
    chaves = 4'b1000;
    tick(3);
    check("filtro_antes_abort", int'(db_estado), 2);
    habilita = 1'b0;
    tick(1);
    check("abort_ocioso", int'(db_estado), 0);
    check("abort_mantem_jogada", int'(jogada), 4'h3);
    chaves = 4'b0000;
    tick(4);
    habilita = 1'b1;
    tick(2);
    check("reabilita_espera", int'(db_estado), 1);

    // Reset in the middle of SOLTA
    p = ciclo;
    chaves = 4'b0100;
    espera(K_FEITA, 4'b0100, p + 4);
    tick(5);
    check("solta_antes_reset", int'(db_estado), 3);
    check("jogada_0100", int'(jogada), 4'h4);
    reset = 1'b0;
    #1;
    check("reset_async_estado", int'(db_estado), 0);
    check("reset_async_jogada", int'(jogada), 0);
    habilita = 1'b0;
    chaves = 4'b0000;
    tick(2);
    reset = 1'b1;
    tick(4);
    check("pos_reset_ocioso", int'(db_estado), 0);
    check("fila_vazia", fila.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
# detector_jogada

Input stage of the memory game: sits between the player switches and the game controller (`circuito_exp5` datapath/control). Synchronizes and debounces the 4 `chaves`, qualifies each press as exactly one play with a single-cycle `jogada_feita` pulse and a held `jogada` value, flags multi-key presses, and raises `timeout` when the player takes too long while a play is expected.

## Interface
- `WIDTH`, 4: number of switches.
- `DEBOUNCE_CYCLES`, 2: consecutive stable samples required for press and release, ≥1.
- `TIMEOUT_CYCLES`, 3000: cycles allowed in ESPERA before timeout (3 s at 1 kHz), ≥2.

Ports:
- `clock`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-low.
- `habilita`  in  1  controller expects a play; level.
- `chaves`  in  WIDTH  raw asynchronous switches.
- `jogada`  out  WIDTH  last qualified play, held.
- `jogada_feita`  out  1  one-cycle pulse, valid one-hot play.
- `jogada_invalida`  out  1  one-cycle pulse, qualified non-one-hot play.
- `timeout`  out  1  one-cycle pulse, no play within TIMEOUT_CYCLES.
- `db_estado`  out  3  state code for debug display.

## Operation
- `chaves` passes a 2-flop synchronizer; all decisions use synchronized value `s`.
- States: OCIOSO=0, ESPERA=1, FILTRO=2, SOLTA=3.
- OCIOSO: `habilita`=1 → ESPERA, timeout counter cleared.
- ESPERA: counter +1 per cycle. `s`≠0 → capture `amostra`=`s`, debounce count=1 (if DEBOUNCE_CYCLES=1, qualify immediately). Counter reaching TIMEOUT_CYCLES with `s`=0 → `timeout` pulse, → OCIOSO.
- FILTRO: counter frozen. `s`==`amostra` → count+1; at DEBOUNCE_CYCLES: `jogada`←`amostra`, pulse `jogada_feita` if one-hot else `jogada_invalida`, → SOLTA. `s`≠`amostra` → ESPERA, count cleared, counter resumes (not cleared).
- SOLTA: wait DEBOUNCE_CYCLES consecutive `s`=0 → ESPERA with counter cleared. Any nonzero `s`, including a different key, restarts the release count; no pulses.
- `habilita`=0 in any state → OCIOSO next edge, no pulses; `jogada` retained.
- Priority per cycle: `habilita`=0 > qualification > timeout. Qualification and timeout cannot coincide (counter frozen outside ESPERA).
- At most one of the three pulses is high in any cycle.

## Timing
- Reset (async): `jogada`=0, all pulses 0, `db_estado`=0, synchronizer, counters, `amostra` = 0.
- All outputs registered.
- Press latency: `chaves` stable before edge k → pulse high during the cycle after edge k+DEBOUNCE_CYCLES+1 (k+3 with default).
- `jogada` updates on the same edge the pulse rises and stays until the next qualification or reset.
- Timeout: entering ESPERA at edge e with no press → `timeout` high after edge e+TIMEOUT_CYCLES, low after e+TIMEOUT_CYCLES+1; `db_estado`=0 from edge e+TIMEOUT_CYCLES.
- Counter width $clog2(TIMEOUT_CYCLES+1), saturation unnecessary (cleared on exit).
- Glitches shorter than DEBOUNCE_CYCLES synchronized samples never produce a pulse.

## Structure
- Shared game package/include: state codes (OCIOSO..SOLTA), default TIMEOUT_CYCLES, `WIDTH`; also used by the controller's `db_estado` decoder.
- One sub-module: `sincronizador` (parameterized-width 2-flop, async active-low reset), reusable for `iniciar`.
- FSM, debounce counter, timeout counter and one-hot check inline.

## Test plan
- Reset low 10 cycles → all outputs 0, `db_estado`=0; release, `habilita`=0 → stays OCIOSO despite `chaves`=0001.
- `habilita`=1, `chaves`=0010 held 5 cycles then 0 → single `jogada_feita` at edge k+3, `jogada`=0010, SOLTA then ESPERA after 2 zero samples; no second pulse.
- 1-cycle glitch `chaves`=0100 in ESPERA → no pulse, `db_estado` returns to 1, timeout counter not reset.
- `chaves`=0011 held 5 cycles → `jogada_invalida` one cycle, `jogada`=0011, `jogada_feita` never high.
- `habilita`=1, no press → no `timeout` through edge 2999 after entry, pulse at edge 3000, then OCIOSO; press at cycle 2990 instead → `jogada_feita`, no timeout.
- `habilita` dropped during FILTRO, and separately `reset` low mid-SOLTA → OCIOSO next edge/immediately, no pulses; `jogada` kept vs. cleared respectively.
